// File: rtl/idli_sqi_m_pkg.sv
// idli_sqi_m_pkg: shared types and constants for the SQI memory controller.
//   slice_t     - 4-bit nibble moved per GCK cycle in each direction
//   sqi_state_t - controller FSM states
//   SQI_RD_OP / SQI_WR_OP / SQI_DUMMY_NIBBLES - default command encoding
//   addr_nib()  - pick one address nibble, index 0 = most significant
package idli_sqi_m_pkg;

    typedef logic [3:0] slice_t;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        ADDR,
        DUMMY,
        DATA
    } sqi_state_t;

    localparam logic [7:0]  SQI_RD_OP         = 8'h03;
    localparam logic [7:0]  SQI_WR_OP         = 8'h02;
    localparam int unsigned SQI_DUMMY_NIBBLES = 2;

    function automatic slice_t addr_nib(input logic [15:0] addr, input logic [1:0] idx);
        slice_t nib;
        case (idx)
            2'd0:    nib = addr[15:12];
            2'd1:    nib = addr[11:8];
            2'd2:    nib = addr[7:4];
            default: nib = addr[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/idli_sqi_m_if.sv
// idli_sqi_m_if: core-side stream handshake plus memory pad signals of one
// SQI controller.
//   slave  modport - the controller (idli_sqi_m)
//   master modport - whoever drives requests and models the memory pads
//   core side : req, wr, addr, end, busy, rd_vld, rd_data, wr_rdy, wr_data
//   pad side  : sck, cs (active low), sio, sio_en, sio input from memory
interface idli_sqi_m_if;
    import idli_sqi_m_pkg::*;

    logic          i_sqi_req;
    logic          i_sqi_wr;
    logic [15:0]   i_sqi_addr;
    logic          i_sqi_end;
    logic          o_sqi_busy;
    logic          o_sqi_rd_vld;
    slice_t        o_sqi_rd_data;
    logic          o_sqi_wr_rdy;
    slice_t        i_sqi_wr_data;
    logic          o_sqi_sck;
    logic          o_sqi_cs;
    slice_t        o_sqi_sio;
    logic          o_sqi_sio_en;
    slice_t        i_sqi_sio;

    modport slave (
        input  i_sqi_req, i_sqi_wr, i_sqi_addr, i_sqi_end, i_sqi_wr_data, i_sqi_sio,
        output o_sqi_busy, o_sqi_rd_vld, o_sqi_rd_data, o_sqi_wr_rdy,
               o_sqi_sck, o_sqi_cs, o_sqi_sio, o_sqi_sio_en
    );

    modport master (
        output i_sqi_req, i_sqi_wr, i_sqi_addr, i_sqi_end, i_sqi_wr_data, i_sqi_sio,
        input  o_sqi_busy, o_sqi_rd_vld, o_sqi_rd_data, o_sqi_wr_rdy,
               o_sqi_sck, o_sqi_cs, o_sqi_sio, o_sqi_sio_en
    );

endinterface

// File: rtl/idli_sqi_m.sv
// idli_sqi_m: quad-SPI (SQI) controller for one 23LC512-class serial SRAM in
// sequential mode. Turns a core read/write stream into
// instruction / address / [dummy] / data nibbles, one nibble per GCK cycle.
//   i_sqi_gck   - core clock; every pad output is launched from a posedge flop
//   i_sqi_rst_n - asynchronous active-low reset; drops CS at once
//   sqi         - slave modport: core handshake and memory pads
// Data moves in whole 16-bit words: an end request waits for word nibble 3.
module idli_sqi_m
    import idli_sqi_m_pkg::*;
#(
    parameter logic [7:0]  RD_OP         = SQI_RD_OP,
    parameter logic [7:0]  WR_OP         = SQI_WR_OP,
    parameter int unsigned DUMMY_NIBBLES = SQI_DUMMY_NIBBLES
) (
    input  logic         i_sqi_gck,
    input  logic         i_sqi_rst_n,
    idli_sqi_m_if.slave  sqi
);

    sqi_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic        end_q, end_d;
    logic        cs_q, sck_en_q;
    slice_t      sio_q, sio_d;
    logic        sio_en_q, sio_en_d;
    logic        rd_vld_q, rd_vld_d;
    slice_t      rd_data_q;
    logic        wr_rdy_q, wr_rdy_d;

    logic [7:0]  op;
    logic        xfer;
    logic        last;

    assign op   = wr_q ? WR_OP : RD_OP;
    // In DATA the word counter advances on core-visible handshakes only, so a
    // read's pipeline fill cycle and a write's drain cycle are not counted.
    assign xfer = wr_rdy_q | rd_vld_q;
    assign last = (state_q == DATA) && xfer && (cnt_q == 2'd3) && (end_q | sqi.i_sqi_end);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        end_d    = end_q;
        sio_d    = sio_q;
        sio_en_d = sio_en_q;
        rd_vld_d = 1'b0;
        wr_rdy_d = wr_rdy_q;

        case (state_q)
            IDLE: begin
                cnt_d    = 2'd0;
                end_d    = 1'b0;
                sio_d    = '0;
                sio_en_d = 1'b0;
                wr_rdy_d = 1'b0;
                if (sqi.i_sqi_req) begin
                    wr_d     = sqi.i_sqi_wr;
                    addr_d   = sqi.i_sqi_addr;
                    state_d  = INSTR;
                    sio_en_d = 1'b1;
                    sio_d    = sqi.i_sqi_wr ? WR_OP[7:4] : RD_OP[7:4];
                end
            end
            INSTR: begin
                if (cnt_q == 2'd0) begin
                    sio_d = op[3:0];
                    cnt_d = 2'd1;
                end else begin
                    sio_d   = addr_nib(addr_q, 2'd0);
                    cnt_d   = 2'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q != 2'd3) begin
                    sio_d = addr_nib(addr_q, cnt_q + 2'd1);
                    // Write data is requested one cycle early so the first
                    // data nibble follows the last address nibble directly.
                    if (cnt_q == 2'd2 && wr_q) wr_rdy_d = 1'b1;
                end else if (wr_q) begin
                    // Nibble 0 was consumed this cycle, so the word counter
                    // enters DATA already at 1.
                    sio_d   = sqi.i_sqi_wr_data;
                    cnt_d   = 2'd1;
                    state_d = DATA;
                end else begin
                    sio_d    = '0;
                    sio_en_d = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = DUMMY;
                end
            end
            DUMMY: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(DUMMY_NIBBLES - 1)) begin
                    cnt_d   = 2'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                end_d = end_q | sqi.i_sqi_end;
                if (xfer) cnt_d = cnt_q + 2'd1;
                if (wr_q) begin
                    if (wr_rdy_q) begin
                        sio_d = sqi.i_sqi_wr_data;
                        if (last) wr_rdy_d = 1'b0;
                    end else begin
                        // final nibble has been on the pins for its cycle
                        state_d = IDLE;
                    end
                end else if (last) begin
                    state_d = IDLE;
                end else begin
                    rd_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE && state_q != IDLE) begin
            sio_d    = '0;
            sio_en_d = 1'b0;
            wr_rdy_d = 1'b0;
            rd_vld_d = 1'b0;
            end_d    = 1'b0;
        end
    end

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            end_q     <= 1'b0;
            cs_q      <= 1'b1;
            sck_en_q  <= 1'b0;
            sio_q     <= '0;
            sio_en_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            wr_rdy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            end_q    <= end_d;
            // CS and the SCK gate come from their own flops so the pads see
            // no decode glitches from the state encoding.
            cs_q     <= (state_d == IDLE);
            sck_en_q <= (state_d != IDLE);
            sio_q    <= sio_d;
            sio_en_q <= sio_en_d;
            rd_vld_q <= rd_vld_d;
            wr_rdy_q <= wr_rdy_d;
            // memory drives on SCK fall (= GCK rise), so sample the nibble
            // presented during the previous cycle
            if (state_q == DATA) rd_data_q <= sqi.i_sqi_sio;
        end
    end

    // SCK rises mid-cycle; the enable only moves on posedge while GCK is high
    // and SCK is already forced low, so no runt pulse can escape.
    assign sqi.o_sqi_sck     = ~i_sqi_gck & sck_en_q;
    assign sqi.o_sqi_cs      = cs_q;
    assign sqi.o_sqi_busy    = ~cs_q;
    assign sqi.o_sqi_sio     = sio_q;
    assign sqi.o_sqi_sio_en  = sio_en_q;
    assign sqi.o_sqi_rd_vld  = rd_vld_q;
    assign sqi.o_sqi_rd_data = rd_data_q;
    assign sqi.o_sqi_wr_rdy  = wr_rdy_q;

endmodule

// File: doc/idli_sqi_m.md
Name: idli_sqi_m

Overview:
- SQI memory controller between the core and one external serial SRAM (23LC512-class, quad mode, sequential).
- Top instantiates two copies: one for the low memory, one for the high memory.
- Converts core read/write stream requests into the instruction/address/dummy/data nibble sequence.
- Moves one 4-bit slice per GCK cycle in each direction.

Parameters:
- RD_OP, 8'h03, SQI read instruction byte.
- WR_OP, 8'h02, SQI write instruction byte.
- DUMMY_NIBBLES, 2, read turnaround nibbles between address and data.

Ports:
- i_sqi_gck  in  1  core clock GCK
- i_sqi_rst_n  in  1  reset, asynchronous, active-low
- i_sqi_req  in  1  start a transaction; honoured only when o_sqi_busy=0
- i_sqi_wr  in  1  transaction is a write (sampled with req)
- i_sqi_addr  in  16  start byte address (sampled with req)
- i_sqi_end  in  1  request stream termination
- o_sqi_busy  out  1  transaction in progress (CS asserted)
- o_sqi_rd_vld  out  1  o_sqi_rd_data holds a read nibble this cycle
- o_sqi_rd_data  out  slice_t  read nibble
- o_sqi_wr_rdy  out  1  i_sqi_wr_data is consumed this cycle
- i_sqi_wr_data  in  slice_t  write nibble
- o_sqi_sck  out  1  memory serial clock
- o_sqi_cs  out  1  chip select, active-low
- o_sqi_sio  out  slice_t  nibble driven to memory
- o_sqi_sio_en  out  1  pad output enable for o_sqi_sio
- i_sqi_sio  in  slice_t  nibble from memory

Behaviour:
- Reset values: cs=1, sck=0, sio=0, sio_en=0, busy=0, rd_vld=0, wr_rdy=0, state=IDLE. Reset mid-transaction deasserts CS immediately (async) and discards the transaction.
- SCK: o_sqi_sck = ~gck & sck_en_q. sck_en_q changes only on posedge gck, so SCK is glitch-free. SCK low whenever CS high.
- Nibble launch: all nibbles are launched from flops at posedge gck. Memory samples on SCK rising (mid-cycle).
- Read data capture: memory drives on SCK falling; the controller samples i_sqi_sio at the next posedge.
- States: IDLE -> INSTR(2) -> ADDR(4) -> [DUMMY(DUMMY_NIBBLES), reads only] -> DATA -> IDLE. The counter is 2-bit, reused per state, MSB nibble first.
- Cycle 0 (IDLE, req=1): latch wr and addr.
- Cycles 1-2 (INSTR): cs=0, busy=1, sio_en=1, op nibbles hi then lo.
- Cycles 3-6 (ADDR): addr[15:12] .. addr[3:0].
- Read, cycles 7-8 (DUMMY): sio_en=0 for turnaround; DUMMY and DATA keep sio_en low.
- Read DATA: from cycle 10, rd_vld=1 with the nibble clocked in cycle 9. Thereafter one nibble every cycle, no stalls.
- Write DATA: wr_rdy=1 in cycles 6 onward. The nibble sampled in cycle n is driven on o_sqi_sio in cycle n+1. First data nibble is on the pins in cycle 7.
- Data is counted in 4-nibble words (2-bit word counter, wraps 3->0).
- i_sqi_end may be asserted any DATA cycle. It is latched and takes effect after the nibble with word counter==3 completes, so only whole 16-bit words are transferred.
- On end: next cycle cs=1, sck_en=0, busy=0, rd_vld/wr_rdy=0, state IDLE. CS is held high at least 1 cycle before any new req.
- Write: wr_rdy drops in the cycle of the final consumed nibble+1. No extra nibble is sampled.
- Read: the final rd_vld is word nibble 3. Nibbles in flight after CS rise are dropped.
- req while busy: ignored, no queueing. req and end in the same IDLE cycle: end ignored.
- Address wrap past 16'hFFFF is handled by the memory (sequential mode). The controller tracks no address.

Decomposition:
- idli_pkg additions:
  - sqi_state_t enum (IDLE, INSTR, ADDR, DUMMY, DATA);
  - SQI_RD_OP/SQI_WR_OP constants;
  - reuse slice_t.
- No sub-module; single flat FSM plus counters.

Test Plan:
- Read req addr=16'h1234, end at first data cycle:
  - sio shows 0,3,1,2,3,4 in cycles 1-6;
  - sio_en=0 from cycle 7;
  - memory model returns A,B,C,D -> rd_vld cycles 10-13 with data A,B,C,D;
  - cs=1 cycle 14.
- Write req addr=16'h00FF, wr_data 5,6,7,8 then end:
  - sio shows 0,2,0,0,F,F, then 5,6,7,8;
  - sio_en=1 throughout;
  - exactly 4 wr_rdy cycles;
  - cs rises after nibble 8.
- end asserted mid-word (data nibble 1) on read -> transfer continues to nibble 3, exactly 4 rd_vld, then idle.
- req pulsed while busy -> no change in pin sequence; second transaction only after busy=0 and a CS-high cycle.
- Async reset during ADDR -> cs=1, sck=0, busy=0 immediately without a clock edge; next req restarts from INSTR.
- Streaming read of 3 words (12 nibbles) -> 12 consecutive rd_vld, no gaps; SCK stays low while cs=1.
